ps2_key_decoder: RTL and testbench

//  Downstream consumer of the PS/2 receiver FIFO (ready/data/nextdata_n handshake).
//  - Pops scan-code bytes and folds E0/F0 prefixes into complete key events.
//  - Tracks the Shift, Ctrl and Caps Lock modifiers and flags typematic repeats.
//  - Buffers events in a small FIFO with a valid/ready output for display and counter logic.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_key_decoder_ascii_map.sv | 66 ++++++
 rtl/ps2_key_decoder.sv | 167 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: special bytes, modifier scan codes, event layout, FSM encoding.
package ps2_pkg;

  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_BAT    = 8'hAA;
  localparam logic [7:0] B_ACK    = 8'hFA;
  localparam logic [7:0] B_ECHO   = 8'hEE;
  localparam logic [7:0] B_RESEND = 8'hFE;
  localparam logic [7:0] B_PAUSE  = 8'hE1;
  localparam logic [7:0] B_ERR0   = 8'h00;
  localparam logic [7:0] B_ERR1   = 8'hFF;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int EV_W = 19;

  typedef struct packed {
    logic       rpt;
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_ev_t;

  // Bit 0 is set only in POP so the pop strobe comes straight off one flop.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_POP  = 2'b01;
  localparam logic [1:0] ST_DEC  = 2'b10;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == B_BAT) || (b == B_ACK) || (b == B_ECHO) || (b == B_RESEND) ||
           (b == B_PAUSE) || (b == B_ERR0) || (b == B_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_ascii_map.sv
// Combinational set-2 scan code to ASCII; letters follow shift^caps, symbols follow shift only.
module ps2_ascii_map (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] let_lo;
  logic [7:0] sym_lo;
  logic [7:0] sym_hi;

  always_comb begin
    let_lo = 8'h00;
    case (code)
      8'h1C: let_lo = "a";  8'h32: let_lo = "b";  8'h21: let_lo = "c";
      8'h23: let_lo = "d";  8'h24: let_lo = "e";  8'h2B: let_lo = "f";
      8'h34: let_lo = "g";  8'h33: let_lo = "h";  8'h43: let_lo = "i";
      8'h3B: let_lo = "j";  8'h42: let_lo = "k";  8'h4B: let_lo = "l";
      8'h3A: let_lo = "m";  8'h31: let_lo = "n";  8'h44: let_lo = "o";
      8'h4D: let_lo = "p";  8'h15: let_lo = "q";  8'h2D: let_lo = "r";
      8'h1B: let_lo = "s";  8'h2C: let_lo = "t";  8'h3C: let_lo = "u";
      8'h2A: let_lo = "v";  8'h1D: let_lo = "w";  8'h22: let_lo = "x";
      8'h35: let_lo = "y";  8'h1A: let_lo = "z";
      default: let_lo = 8'h00;
    endcase
  end

  always_comb begin
    sym_lo = 8'h00;
    sym_hi = 8'h00;
    case (code)
      8'h16: {sym_lo, sym_hi} = {"1", "!"};
      8'h1E: {sym_lo, sym_hi} = {"2", "@"};
      8'h26: {sym_lo, sym_hi} = {"3", "#"};
      8'h25: {sym_lo, sym_hi} = {"4", "$"};
      8'h2E: {sym_lo, sym_hi} = {"5", "%"};
      8'h36: {sym_lo, sym_hi} = {"6", "^"};
      8'h3D: {sym_lo, sym_hi} = {"7", "&"};
      8'h3E: {sym_lo, sym_hi} = {"8", "*"};
      8'h46: {sym_lo, sym_hi} = {"9", "("};
      8'h45: {sym_lo, sym_hi} = {"0", ")"};
      8'h29: {sym_lo, sym_hi} = {" ", " "};
      8'h4E: {sym_lo, sym_hi} = {"-", "_"};
      8'h55: {sym_lo, sym_hi} = {"=", "+"};
      8'h54: {sym_lo, sym_hi} = {"[", "{"};
      8'h5B: {sym_lo, sym_hi} = {"]", "}"};
      8'h5D: {sym_lo, sym_hi} = {"\\", "|"};
      8'h4C: {sym_lo, sym_hi} = {";", ":"};
      8'h52: {sym_lo, sym_hi} = {"'", "\""};
      8'h41: {sym_lo, sym_hi} = {",", "<"};
      8'h49: {sym_lo, sym_hi} = {".", ">"};
      8'h4A: {sym_lo, sym_hi} = {"/", "?"};
      8'h0E: {sym_lo, sym_hi} = {8'h60, 8'h7E};
      default: {sym_lo, sym_hi} = 16'h0000;
    endcase
  end

  always_comb begin
    if (let_lo != 8'h00)
      ascii = (shift ^ caps) ? (let_lo - 8'h20) : let_lo;
    else
      ascii = shift ? sym_hi : sym_lo;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds PS/2 bytes into key events with modifier tracking; one byte per 3 cycles, ev_valid after edge 2.
// Full queue without a same-edge pop drops the event and sets sticky ev_overflow.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_ready,
  input  logic [7:0]       ps2_data,
  output logic             ps2_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic             shift,
  output logic             ctrl,
  output logic             caps_lock,
  output logic [CNT_W-1:0] key_count,
  output logic             ev_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] KEY_ONE = CNT_W'(1);

  logic [1:0]    state;
  logic [7:0]    byte_q;
  logic          ext_f, brk_f;
  logic [7:0]    held_code;
  logic          held_ext, held_vld;
  logic [7:0]    map_ascii;
  logic          in_dec, emit, held_hit, is_rpt;
  ps2_ev_t       new_ev, head_q, head_nxt;
  ps2_ev_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count;
  logic          full, push, pop, empty_after_pop;

  assign ps2_nextdata_n = ~state[0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= ST_IDLE;
      byte_q <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: if (ps2_ready) begin
          byte_q <= ps2_data;
          state  <= ST_POP;
        end
        ST_POP:  state <= ST_DEC;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps2_ascii_map u_ascii_map (
    .code  (byte_q),
    .shift (shift),
    .caps  (caps_lock),
    .ascii (map_ascii)
  );

  assign in_dec   = (state == ST_DEC);
  assign emit     = in_dec && (byte_q != B_EXT) && (byte_q != B_BRK) && !is_discard(byte_q);
  assign held_hit = held_vld && (held_code == byte_q) && (held_ext == ext_f);
  assign is_rpt   = !brk_f && held_hit;

  always_comb begin
    new_ev.rpt   = is_rpt;
    new_ev.brk   = brk_f;
    new_ev.ext   = ext_f;
    new_ev.code  = byte_q;
    new_ev.ascii = (brk_f || ext_f) ? 8'h00 : map_ascii;
  end

  // Modifiers update after DEC, so the event's own ascii sees the old levels.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      held_vld  <= 1'b0;
      shift     <= 1'b0;
      ctrl      <= 1'b0;
      caps_lock <= 1'b0;
      key_count <= '0;
    end else if (in_dec) begin
      if (byte_q == B_EXT) begin
        ext_f <= 1'b1;
      end else if (byte_q == B_BRK) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
      if (emit) begin
        if (!brk_f) begin
          held_code <= byte_q;
          held_ext  <= ext_f;
          held_vld  <= 1'b1;
        end else if (held_hit) begin
          held_vld <= 1'b0;
        end
        if (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT) shift <= !brk_f;
        if (byte_q == SC_CTRL) ctrl <= !brk_f;
        if (byte_q == SC_CAPS && !brk_f && !is_rpt) caps_lock <= !caps_lock;
        if (!brk_f && !is_rpt) key_count <= key_count + KEY_ONE;
      end
    end
  end

  assign full            = (count == CNT_FULL);
  assign pop             = ev_valid && ev_ready;
  assign push            = emit && (!full || pop);
  assign rd_nxt          = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign empty_after_pop = (count == '0) || (pop && count == CNT_ONE);

  // The head register bypasses memory when a push lands in an otherwise empty queue.
  always_comb begin
    if (push && empty_after_pop)
      head_nxt = new_ev;
    else
      head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_ev;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_q      <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_nxt;
      if (push && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push)
        count <= count - CNT_ONE;
      if (emit && full && !pop) ev_overflow <= 1'b1;
      head_q <= head_nxt;
    end
  end

  assign ev_valid  = (count != '0);
  assign ev_code   = head_q.code;
  assign ev_ext    = head_q.ext;
  assign ev_break  = head_q.brk;
  assign ev_repeat = head_q.rpt;
  assign ev_ascii  = head_q.ascii;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with an event scoreboard checked on every consumed head event.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_ready = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_nextdata_n;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_repeat;
  logic [7:0] ev_ascii;
  logic       shift, ctrl, caps_lock;
  logic [7:0] key_count;
  logic       ev_overflow;

  int n_checks = 0;
  int n_fail = 0;
  logic [18:0] sb [$];
  logic [18:0] obs_ev, exp_ev;

  always #5 clk = ~clk;

  ps2_key_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .ps2_ready      (ps2_ready),
    .ps2_data       (ps2_data),
    .ps2_nextdata_n (ps2_nextdata_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_break       (ev_break),
    .ev_repeat      (ev_repeat),
    .ev_ascii       (ev_ascii),
    .shift          (shift),
    .ctrl           (ctrl),
    .caps_lock      (caps_lock),
    .key_count      (key_count),
    .ev_overflow    (ev_overflow)
  );

  // Consumer side: every accepted head event is checked against the oldest expectation.
  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      obs_ev = {ev_repeat, ev_break, ev_ext, ev_code, ev_ascii};
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL ev_unexpected: observed %h expected no event", obs_ev);
      end
      if (sb.size() != 0) begin
        exp_ev = sb.pop_front();
        n_checks++;
        assert (obs_ev === exp_ev) else begin
          n_fail++;
          $error("FAIL ev_head: observed %h expected %h", obs_ev, exp_ev);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                           input logic rpt, input logic [7:0] asc);
    sb.push_back({rpt, brk, ext, code, asc});
  endtask

  task automatic send(input logic [7:0] b, input logic pop_in_dec);
    bit got;
    got = 1'b0;
    tick;
    ps2_data  = b;
    ps2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!ps2_nextdata_n) begin
        got = 1'b1;
        break;
      end
    end
    ps2_ready = 1'b0;
    check("pop_strobe", {31'd0, got}, 32'd1);
    tick;
    if (pop_in_dec) ev_ready = 1'b1;
    tick;
    if (pop_in_dec) ev_ready = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !ev_valid) break;
      @(negedge clk);
    end
    check("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_nextdata_n"}, {31'd0, ps2_nextdata_n}, 1);
    check({tag, "_ev_valid"}, {31'd0, ev_valid}, 0);
    check({tag, "_ev_fields"}, {13'd0, ev_repeat, ev_break, ev_ext, ev_code, ev_ascii}, 0);
    check({tag, "_mods"}, {29'd0, shift, ctrl, caps_lock}, 0);
    check({tag, "_key_count"}, {24'd0, key_count}, 0);
    check({tag, "_overflow"}, {31'd0, ev_overflow}, 0);
  endtask

  int lows, adj;
  logic prev_nd;

  initial begin
    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    tick;
    clrn = 1'b1;

    // Latency: ready high at edge 0 -> strobe in cycle 1, ev_valid after edge 2
    expect_ev(8'h16, 0, 0, 0, 8'h31);
    tick;
    ps2_data  = 8'h16;
    ps2_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_c1_strobe", {31'd0, ps2_nextdata_n}, 0);
    check("lat_c1_valid", {31'd0, ev_valid}, 0);
    ps2_ready = 1'b0;
    @(negedge clk);
    check("lat_c2_strobe", {31'd0, ps2_nextdata_n}, 1);
    check("lat_c2_valid", {31'd0, ev_valid}, 0);
    @(negedge clk);
    check("lat_c3_valid", {31'd0, ev_valid}, 1);
    drain;
    check("lat_key_count", {24'd0, key_count}, 1);

    // Press / release 'a'
    expect_ev(8'h1C, 0, 0, 0, 8'h61);
    expect_ev(8'h1C, 0, 1, 0, 8'h00);
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain;
    check("t1_key_count", {24'd0, key_count}, 2);

    // Shift then caps lock
    expect_ev(8'h12, 0, 0, 0, 8'h00);
    send(8'h12, 0);
    check("t2_shift_on", {31'd0, shift}, 1);
    expect_ev(8'h1C, 0, 0, 0, 8'h41);
    expect_ev(8'h1C, 0, 1, 0, 8'h00);
    expect_ev(8'h12, 0, 1, 0, 8'h00);
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h12, 0);
    check("t2_shift_off", {31'd0, shift}, 0);
    expect_ev(8'h58, 0, 0, 0, 8'h00);
    expect_ev(8'h58, 0, 1, 0, 8'h00);
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
    check("t2_caps_on", {31'd0, caps_lock}, 1);
    expect_ev(8'h1C, 0, 0, 0, 8'h41);
    expect_ev(8'h1C, 0, 1, 0, 8'h00);
    expect_ev(8'h58, 0, 0, 0, 8'h00);
    expect_ev(8'h58, 0, 1, 0, 8'h00);
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
    check("t2_caps_off", {31'd0, caps_lock}, 0);
    drain;
    check("t2_key_count", {24'd0, key_count}, 7);

    // Extended keys and E0-14 ctrl
    expect_ev(8'h75, 1, 0, 0, 8'h00);
    expect_ev(8'h75, 1, 1, 0, 8'h00);
    expect_ev(8'h14, 1, 0, 0, 8'h00);
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'h14, 0);
    check("t3_ctrl_on", {31'd0, ctrl}, 1);
    expect_ev(8'h14, 1, 1, 0, 8'h00);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h14, 0);
    check("t3_ctrl_off", {31'd0, ctrl}, 0);
    drain;

    // Typematic repeat, then a discard byte clearing a pending E0
    expect_ev(8'h1C, 0, 0, 0, 8'h61);
    expect_ev(8'h1C, 0, 0, 1, 8'h61);
    expect_ev(8'h1C, 0, 0, 1, 8'h61);
    expect_ev(8'h1C, 0, 1, 0, 8'h00);
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain;
    check("t4_key_count", {24'd0, key_count}, 10);
    expect_ev(8'h1C, 0, 0, 0, 8'h61);
    expect_ev(8'h1C, 0, 1, 0, 8'h00);
    send(8'hE0, 0); send(8'hAA, 0); send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    drain;
    check("t4b_key_count", {24'd0, key_count}, 11);

    // Overflow with push+pop on a full queue
    ev_ready = 1'b0;
    expect_ev(8'h16, 0, 0, 0, 8'h31);
    expect_ev(8'h1E, 0, 0, 0, 8'h32);
    expect_ev(8'h26, 0, 0, 0, 8'h33);
    expect_ev(8'h25, 0, 0, 0, 8'h34);
    expect_ev(8'h36, 0, 0, 0, 8'h36);
    send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0);
    check("t5_full_valid", {31'd0, ev_valid}, 1);
    check("t5_full_no_ovf", {31'd0, ev_overflow}, 0);
    send(8'h36, 1);
    check("t5_pushpop_no_ovf", {31'd0, ev_overflow}, 0);
    send(8'h2E, 0);
    check("t5_drop_ovf", {31'd0, ev_overflow}, 1);
    ev_ready = 1'b1;
    drain;
    check("t5_empty", {31'd0, ev_valid}, 0);
    check("t5_ovf_sticky", {31'd0, ev_overflow}, 1);
    check("t5_key_count", {24'd0, key_count}, 17);

    // Caps on before reset so the reset visibly clears it
    expect_ev(8'h58, 0, 0, 0, 8'h00);
    expect_ev(8'h58, 0, 1, 0, 8'h00);
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0);
    drain;
    check("t6_caps_pre", {31'd0, caps_lock}, 1);

    // ps2_ready held high: one strobe per 3 cycles
    tick;
    ps2_data  = 8'hAA;
    ps2_ready = 1'b1;
    lows = 0;
    adj = 0;
    prev_nd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin
        lows++;
        if (!prev_nd) adj++;
      end
      prev_nd = ps2_nextdata_n;
    end
    tick;
    ps2_ready = 1'b0;
    tick; tick; tick;
    check("t6_strobe_count", lows, 4);
    check("t6_strobe_width", adj, 0);

    // Reset asserted during POP
    tick;
    ps2_data  = 8'h1C;
    ps2_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_in_pop", {31'd0, ps2_nextdata_n}, 0);
    #1;
    clrn = 1'b0;
    ps2_ready = 1'b0;
    #1;
    check_all_zero("t6_rst");
    tick; tick;
    clrn = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!ps2_nextdata_n) lows++;
    end
    check("t6_no_strobe_after_rst", lows, 0);
    check("t6_no_event_after_rst", {31'd0, ev_valid}, 0);

    // key_count wraps FF -> 00
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 1) begin
        expect_ev(8'h1E, 0, 0, 0, 8'h32);
        send(8'h1E, 0);
      end else begin
        expect_ev(8'h16, 0, 0, 0, 8'h31);
        send(8'h16, 0);
      end
      if (i == 254) check("wrap_ff", {24'd0, key_count}, 32'hFF);
    end
    check("wrap_00", {24'd0, key_count}, 0);
    drain;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
